// File: rtl/rif_reg_bank.sv
// RIF register bank: ID, interrupt status/enable/set and NUM_RW_REGS byte-strobed RW registers; zero-latency decode, one-cycle registered irq.
// No backpressure: every request completes in its own cycle. Edge-triggered sources are enabled with RIF_REG_BANK_IRQ_EDGE_EN.
module rif_reg_bank #(
   parameter int          AXI_ADDR_WIDTH = 12,
   parameter int          AXI_DATA_WIDTH = 32,
   parameter int          AXI_BYTE_COUNT = AXI_DATA_WIDTH / 8,
   parameter int          NUM_RW_REGS    = 4,
   parameter int          NUM_IRQ        = 8,
   parameter logic [31:0] ID_VALUE       = 32'hA5A5_0001
) (
   input  logic                                  aclk,
   input  logic                                  aresetn,
   input  logic [AXI_ADDR_WIDTH-1:0]             rif_waddr,
   input  logic                                  rif_wr_req,
   input  logic [AXI_BYTE_COUNT-1:0]             rif_wstrb,
   input  logic [AXI_DATA_WIDTH-1:0]             rif_wdata,
   output logic                                  rif_wvalid,
   input  logic [AXI_ADDR_WIDTH-1:0]             rif_raddr,
   input  logic                                  rif_rd_req,
   output logic [AXI_DATA_WIDTH-1:0]             rif_rdata,
   output logic                                  rif_rvalid,
   input  logic [NUM_IRQ-1:0]                    irq_src,
   output logic [NUM_RW_REGS*AXI_DATA_WIDTH-1:0] rw_regs,
   output logic                                  irq
);

   localparam int W          = AXI_DATA_WIDTH;
   localparam int SHIFT      = $clog2(AXI_BYTE_COUNT);
   localparam int IDX_STATUS = 1;
   localparam int IDX_ENABLE = 2;
   localparam int IDX_SET    = 3;
   localparam int IDX_RW0    = 4;
   localparam int IDX_LAST   = IDX_RW0 + NUM_RW_REGS - 1;

   if (AXI_DATA_WIDTH != 32 && AXI_DATA_WIDTH != 64) begin : g_bad_width
      $fatal(1, "rif_reg_bank: AXI_DATA_WIDTH must be 32 or 64");
   end
   if (NUM_IRQ < 1 || NUM_IRQ > AXI_DATA_WIDTH) begin : g_bad_irq
      $fatal(1, "rif_reg_bank: NUM_IRQ must be 1..AXI_DATA_WIDTH");
   end
   if (NUM_RW_REGS < 1) begin : g_bad_rw
      $fatal(1, "rif_reg_bank: NUM_RW_REGS must be >= 1");
   end

   logic [31:0]        wr_idx;
   logic [31:0]        rd_idx;
   logic               wr_go;
   logic [W-1:0]       wmask;
   logic [W-1:0]       wbits;
   logic [NUM_IRQ-1:0] status;
   logic [NUM_IRQ-1:0] enable;
   logic [NUM_IRQ-1:0] status_nxt;
   logic [NUM_IRQ-1:0] enable_nxt;
   logic [NUM_IRQ-1:0] sw_clr;
   logic [NUM_IRQ-1:0] sw_set;
   logic [NUM_IRQ-1:0] set_hw;
   logic [W-1:0]       rw_q [NUM_RW_REGS];

   // Word index decode: byte-lane address bits are ignored.
   assign wr_idx     = 32'(rif_waddr >> SHIFT);
   assign rd_idx     = 32'(rif_raddr >> SHIFT);
   assign wr_go      = rif_wr_req && (wr_idx >= 32'(IDX_STATUS)) && (wr_idx <= 32'(IDX_LAST));
   assign rif_wvalid = wr_go;

   always_comb begin
      wmask = '0;
      for (int b = 0; b < AXI_BYTE_COUNT; b++) begin
         wmask[b*8 +: 8] = {8{rif_wstrb[b]}};
      end
   end

   assign wbits  = rif_wdata & wmask;
   assign sw_clr = (wr_go && wr_idx == 32'(IDX_STATUS)) ? wbits[NUM_IRQ-1:0] : '0;
   assign sw_set = (wr_go && wr_idx == 32'(IDX_SET))    ? wbits[NUM_IRQ-1:0] : '0;

`ifdef RIF_REG_BANK_IRQ_EDGE_EN
   logic [NUM_IRQ-1:0] irq_src_q;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         irq_src_q <= '0;
      end else begin
         irq_src_q <= irq_src;
      end
   end

   assign set_hw = irq_src & ~irq_src_q;
`else
   assign set_hw = irq_src;
`endif

   // Hardware set is OR-ed in last so it beats a same-cycle W1C.
   assign status_nxt = (status & ~sw_clr) | set_hw | sw_set;
   assign enable_nxt = (wr_go && wr_idx == 32'(IDX_ENABLE))
                       ? ((enable & ~wmask[NUM_IRQ-1:0]) | wbits[NUM_IRQ-1:0])
                       : enable;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         status <= '0;
         enable <= '0;
         irq    <= 1'b0;
         for (int i = 0; i < NUM_RW_REGS; i++) begin
            rw_q[i] <= '0;
         end
      end else begin
         status <= status_nxt;
         enable <= enable_nxt;
         irq    <= |(status & enable);
         for (int i = 0; i < NUM_RW_REGS; i++) begin
            if (wr_go && wr_idx == 32'(IDX_RW0 + i)) begin
               rw_q[i] <= (rw_q[i] & ~wmask) | wbits;
            end
         end
      end
   end

   for (genvar i = 0; i < NUM_RW_REGS; i++) begin : g_flat
      assign rw_regs[i*W +: W] = rw_q[i];
   end

   // Read mux returns pre-edge state; IRQ_SET and unused upper bits read as zero.
   always_comb begin
      rif_rvalid = 1'b0;
      rif_rdata  = '0;
      if (rif_rd_req && rd_idx <= 32'(IDX_LAST)) begin
         rif_rvalid = 1'b1;
         if (rd_idx == 32'd0) begin
            rif_rdata = W'(ID_VALUE);
         end else if (rd_idx == 32'(IDX_STATUS)) begin
            rif_rdata[NUM_IRQ-1:0] = status;
         end else if (rd_idx == 32'(IDX_ENABLE)) begin
            rif_rdata[NUM_IRQ-1:0] = enable;
         end else begin
            for (int i = 0; i < NUM_RW_REGS; i++) begin
               if (rd_idx == 32'(IDX_RW0 + i)) begin
                  rif_rdata = rw_q[i];
               end
            end
         end
      end
   end

endmodule
